wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the address width of all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data width of all ports.
REQ-003 SHALL have parameter TIMEOUT, default 16, legal range 2..255, the maximum number of slave cycles without ack before an error is raised.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with the following ports:
- clk  input  1  sole clock.
- rstn_i  input  1  asynchronous active-low reset.
- mN_cyc_i  input  1  master N bus cycle request (N = 0, 1).
- mN_stb_i  input  1  master N strobe.
- mN_we_i  input  1  master N write enable.
- mN_sel_i  input  4  master N byte select.
- mN_adr_i  input  ADDR_WIDTH  master N address.
- mN_dat_i  input  DATA_WIDTH  master N write data.
- mN_dat_o  output  DATA_WIDTH  read data returned to master N.
- mN_ack_o  output  1  acknowledge to master N.
- mN_err_o  output  1  timeout error to master N.
- s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle, strobe and write enable.
- s_sel_o  output  4  slave byte select.
- s_adr_o  output  ADDR_WIDTH  slave address.
- s_dat_o  output  DATA_WIDTH  slave write data.
- s_dat_i  input  DATA_WIDTH  slave read data.
- s_ack_i  input  1  slave acknowledge.
- grant_o  output  2  one-hot current owner; 00 when idle.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, OWN and ERR, with a registered owner bit and a registered last_grant bit.
REQ-006 In IDLE, when any mN_cyc_i is high, the FSM SHALL go to OWN on the next edge and latch the owner; arbitration latency is 1 cycle.
REQ-007 When both masters request in the same IDLE cycle, the owner SHALL be the master that is not last_grant (round-robin); a single requester always wins.
REQ-008 In IDLE, all s_* outputs SHALL be 0, all mN_ack_o/mN_err_o SHALL be 0, and grant_o SHALL be 00.
REQ-009 In OWN, s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL combinationally follow the owner's inputs.
REQ-010 In OWN, the owner SHALL receive mN_ack_o = s_ack_i and mN_dat_o = s_dat_i.
REQ-011 The non-owner SHALL see ack = 0, err = 0 and dat_o = 0.
REQ-012 The grant SHALL be held for multiple transfers while the owner keeps mN_cyc_i high; the other master's requests are ignored during that time.
REQ-013 When the owner deasserts mN_cyc_i in OWN:
- s_cyc_o SHALL drop combinationally in the same cycle;
- the FSM SHALL go to IDLE on the next edge and set last_grant to the owner;
- at least one IDLE cycle SHALL separate tenures.
REQ-014 A TIMEOUT counter of width $clog2(TIMEOUT+1) SHALL increment in each OWN cycle with s_stb_o=1 and s_ack_i=0, and SHALL clear on s_ack_i=1, outside OWN, and on entry to ERR.
REQ-015 When the counter equals TIMEOUT-1, s_ack_i=0 and the strobe is active, the FSM SHALL go to ERR; if s_ack_i=1 in that same cycle, the ack SHALL win and no error is raised.
REQ-016 ERR SHALL last exactly 1 cycle:
- owner mN_err_o=1, mN_ack_o=0;
- s_stb_o=0 and s_cyc_o held;
- grant_o unchanged;
- then return to OWN, or to IDLE if the owner's cyc is low.
REQ-017 s_ack_i asserted in IDLE or ERR SHALL be ignored and SHALL not be forwarded.
REQ-018 mN_ack_o and mN_err_o SHALL never both be 1, and SHALL never be 1 for the non-owner.

Reset
REQ-019 On rstn_i=0, the block SHALL asynchronously force:
- FSM to IDLE, owner=0, last_grant=1 (so m0 wins the first contention), counter=0;
- all outputs to 0, including mid-transfer.
REQ-020 After release, the first arbitration SHALL occur on the first edge with rstn_i=1 and a cyc request present.

Verification
REQ-021 Bench SHALL cover contention: m0 and m1 assert cyc in the same cycle after reset -> grant_o=01 on the next cycle; m0 drops cyc -> 1 IDLE cycle, then grant_o=10.
REQ-022 Bench SHALL cover the held grant: m1 owns and issues 3 back-to-back reads with ack each cycle, while m0 requests -> m0_ack_o stays 0 and grant_o=10 throughout.
REQ-023 Bench SHALL cover timeout: TIMEOUT=4, m0 strobes, slave never acks -> m0_err_o=1 for exactly 1 cycle, 4 cycles after the strobe, with s_stb_o=0 in that cycle.
REQ-024 Bench SHALL cover the boundary race: s_ack_i=1 in the cycle the counter equals TIMEOUT-1 -> m0_ack_o=1, m0_err_o stays 0.
REQ-025 Bench SHALL cover reset mid-operation: rstn_i low during an active write -> s_cyc_o=0 and grant_o=00 immediately; after release, m1 alone requests -> grant_o=10.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter: round-robin grant held for a whole bus tenure,
// with a per-tenure ack timeout that reports a one-cycle error to the owner.
module wb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [3:0]            s_sel_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    input  logic                  s_ack_i,
    output logic [1:0]            grant_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic             owner_r, owner_s;
    logic             last_grant_r, last_grant_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic                  own_cyc_s;
    logic                  own_stb_s;
    logic                  own_we_s;
    logic [3:0]            own_sel_s;
    logic [ADDR_WIDTH-1:0] own_adr_s;
    logic [DATA_WIDTH-1:0] own_dat_s;

    // Select the current owner's request signals.
    always_comb begin
        if (owner_r) begin
            own_cyc_s = m1_cyc_i;
            own_stb_s = m1_stb_i;
            own_we_s  = m1_we_i;
            own_sel_s = m1_sel_i;
            own_adr_s = m1_adr_i;
            own_dat_s = m1_dat_i;
        end else begin
            own_cyc_s = m0_cyc_i;
            own_stb_s = m0_stb_i;
            own_we_s  = m0_we_i;
            own_sel_s = m0_sel_i;
            own_adr_s = m0_adr_i;
            own_dat_s = m0_dat_i;
        end
    end

    // Next-state, arbitration and timeout counter logic.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_grant_s = last_grant_r;
        cnt_s        = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = '0;
                if (m0_cyc_i || m1_cyc_i) begin
                    state_s = ST_OWN;
                    if (m0_cyc_i && m1_cyc_i) begin
                        owner_s = ~last_grant_r;
                    end else begin
                        owner_s = m1_cyc_i;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                if (!own_cyc_s) begin
                    state_s      = ST_IDLE;
                    last_grant_s = owner_r;
                    cnt_s        = '0;
                end else if (s_ack_i) begin
                    cnt_s = '0;
                end else if (own_stb_s) begin
                    // An ack in the boundary cycle is handled above, so it wins.
                    if (cnt_r == CNT_LAST) begin
                        state_s = ST_ERR;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_ERR: begin
                cnt_s = '0;
                if (own_cyc_s) begin
                    state_s = ST_OWN;
                end else begin
                    state_s      = ST_IDLE;
                    last_grant_s = owner_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State, owner, round-robin history and timeout counter registers.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r      <= ST_IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= '0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
        end
    end

    // Bus routing: everything is quiet unless a tenure is in progress.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = 4'h0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = 2'b00;
        case (state_r)
            ST_IDLE: begin
                grant_o = 2'b00;
            end
            ST_OWN: begin
                s_cyc_o = own_cyc_s;
                s_stb_o = own_stb_s;
                s_we_o  = own_we_s;
                s_sel_o = own_sel_s;
                s_adr_o = own_adr_s;
                s_dat_o = own_dat_s;
                grant_o = owner_r ? 2'b10 : 2'b01;
                if (owner_r) begin
                    m1_ack_o = s_ack_i;
                    m1_dat_o = s_dat_i;
                end else begin
                    m0_ack_o = s_ack_i;
                    m0_dat_o = s_dat_i;
                end
            end
            ST_ERR: begin
                // Strobe is withdrawn for the error cycle; the slave ack is ignored.
                s_cyc_o = own_cyc_s;
                s_stb_o = 1'b0;
                s_we_o  = own_we_s;
                s_sel_o = own_sel_s;
                s_adr_o = own_adr_s;
                s_dat_o = own_dat_s;
                grant_o = owner_r ? 2'b10 : 2'b01;
                if (owner_r) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            default: begin
                grant_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed contention/hold/timeout/reset
// scenarios followed by random traffic, checked against a behavioural model.
module tb_wb_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rstn_i;
    logic          cyc [2];
    logic          stb [2];
    logic          we  [2];
    logic [3:0]    sel [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wdat[2];
    logic [DW-1:0] rdat[2];
    logic          ack [2];
    logic          err [2];
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]    s_sel_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic [1:0]    grant_o;

    typedef struct packed {
        logic [1:0]    grant;
        logic          s_cyc;
        logic          s_stb;
        logic          s_we;
        logic [3:0]    s_sel;
        logic [AW-1:0] s_adr;
        logic [DW-1:0] s_dat;
        logic [1:0]    ack;
        logic [1:0]    err;
        logic [DW-1:0] dat0;
        logic [DW-1:0] dat1;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: who owns the bus, who won last, and how long the owner has waited.
    int mdl_owner;
    int mdl_last;
    int mdl_waits;
    bit mdl_err;

    bit done = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn_i(rstn_i),
        .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
        .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]), .m0_dat_o(rdat[0]),
        .m0_ack_o(ack[0]), .m0_err_o(err[0]),
        .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
        .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]), .m1_dat_o(rdat[1]),
        .m1_ack_o(ack[1]), .m1_err_o(err[1]),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        mdl_owner = -1;
        mdl_last  = 1;
        mdl_waits = 0;
        mdl_err   = 1'b0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int   o;
        e = '0;
        o = mdl_owner;
        if (rstn_i && o >= 0) begin
            e.grant = (o == 1) ? 2'b10 : 2'b01;
            e.s_cyc = cyc[o];
            e.s_we  = we[o];
            e.s_sel = sel[o];
            e.s_adr = adr[o];
            e.s_dat = wdat[o];
            if (mdl_err) begin
                e.err[o] = 1'b1;
            end else begin
                e.s_stb  = stb[o];
                e.ack[o] = s_ack_i;
                if (o == 0) e.dat0 = s_dat_i;
                else        e.dat1 = s_dat_i;
            end
        end
        return e;
    endfunction

    function automatic void model_update();
        int o;
        o = mdl_owner;
        if (o < 0) begin
            if (cyc[0] && cyc[1]) mdl_owner = 1 - mdl_last;
            else if (cyc[0])      mdl_owner = 0;
            else if (cyc[1])      mdl_owner = 1;
            mdl_waits = 0;
        end else if (!cyc[o]) begin
            mdl_last  = o;
            mdl_owner = -1;
            mdl_waits = 0;
            mdl_err   = 1'b0;
        end else if (mdl_err) begin
            mdl_err   = 1'b0;
            mdl_waits = 0;
        end else if (s_ack_i) begin
            mdl_waits = 0;
        end else if (stb[o]) begin
            mdl_waits++;
            if (mdl_waits == TO) begin
                mdl_err   = 1'b1;
                mdl_waits = 0;
            end
        end
    endfunction

    task automatic set_m(input int n, input bit c, input bit s, input bit w);
        cyc[n] = c;
        stb[n] = s;
        we[n]  = w;
    endtask

    // One bus cycle: fresh data, queue the expectation, advance the model at the edge.
    task automatic step();
        for (int n = 0; n < 2; n++) begin
            sel[n]  = 4'($urandom);
            adr[n]  = $urandom;
            wdat[n] = $urandom;
        end
        s_dat_i = $urandom;
        sb_q.push_back(model_out());
        @(posedge clk);
        if (rstn_i) model_update();
        else        model_reset();
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("grant", 128'(grant_o), 128'(e.grant));
                chk("slave_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o}),
                    128'({e.s_cyc, e.s_stb, e.s_we, e.s_sel, e.s_adr, e.s_dat}));
                chk("m0_resp", 128'({ack[0], err[0], rdat[0]}), 128'({e.ack[0], e.err[0], e.dat0}));
                chk("m1_resp", 128'({ack[1], err[1], rdat[1]}), 128'({e.ack[1], e.err[1], e.dat1}));
            end
            if (done) begin
                chk("sb_drain", 128'(sb_q.size()), 128'(0));
                $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    // Stimulus: directed scenarios, then random traffic with occasional resets.
    initial begin
        rstn_i  = 1'b0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        for (int n = 0; n < 2; n++) begin
            set_m(n, 1'b0, 1'b0, 1'b0);
            sel[n]  = 4'h0;
            adr[n]  = '0;
            wdat[n] = '0;
        end
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        rstn_i = 1'b1;
        step();

        // Contention right after reset: m0 wins, then m1 after one idle cycle.
        set_m(0, 1'b1, 1'b1, 1'b1);
        set_m(1, 1'b1, 1'b1, 1'b0);
        s_ack_i = 1'b1;
        repeat (3) step();
        set_m(0, 1'b0, 1'b0, 1'b0);
        repeat (2) step();

        // m1 holds the grant for three acked reads while m0 keeps requesting.
        set_m(0, 1'b1, 1'b1, 1'b0);
        repeat (3) step();

        // m1 releases; m0 takes over and the slave stays silent until timeout.
        set_m(1, 1'b0, 1'b0, 1'b0);
        set_m(0, 1'b1, 1'b1, 1'b1);
        s_ack_i = 1'b0;
        repeat (2) step();
        repeat (5) step();

        // Boundary race: ack arrives in the last cycle before the timeout would fire.
        repeat (3) step();
        s_ack_i = 1'b1;
        step();
        s_ack_i = 1'b0;
        step();

        // Reset during an active m0 write, then m1 alone requests.
        rstn_i = 1'b0;
        repeat (2) step();
        set_m(0, 1'b0, 1'b0, 1'b0);
        set_m(1, 1'b1, 1'b1, 1'b1);
        rstn_i = 1'b1;
        repeat (3) step();
        set_m(1, 1'b0, 1'b0, 1'b0);
        repeat (2) step();

        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 7) == 0) cyc[n] = ~cyc[n];
                stb[n] = 1'($urandom);
                we[n]  = 1'($urandom);
            end
            s_ack_i = ($urandom_range(0, 3) == 0);
            rstn_i  = ($urandom_range(0, 99) != 0);
            step();
        end

        rstn_i  = 1'b1;
        s_ack_i = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0);
        set_m(1, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        done = 1'b1;
    end

endmodule
